// File: rtl/cordic_iter_ctrl.sv
// Iterative rotation-mode CORDIC: one shift-add stage reused over ITERS micro-rotations,
// with valid/ready handshakes on operand input and result output.
module cordic_iter_ctrl #(
  parameter int unsigned ITERS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x_in,
  input  logic [31:0] y_in,
  input  logic [31:0] z_in,
  output logic        busy,
  output logic [4:0]  iter_idx,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] x_out,
  output logic [31:0] y_out,
  output logic [31:0] z_out
);

  typedef enum logic [1:0] {StIdle, StIter, StDone} state_e;

  localparam logic [4:0] LastIdx = 5'(ITERS - 1);

  state_e      state_q, state_d;
  logic [31:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic [4:0]  idx_q, idx_d;
  logic [31:0] x_sh, y_sh, atan;

  // round(atan(2^-i) * 2^29); from i = 11 the value is exactly 2^(29-i) after rounding.
  function automatic logic [31:0] atan_lut(input logic [4:0] i);
    case (i)
      5'd0:    atan_lut = 32'd421657428;
      5'd1:    atan_lut = 32'd248918915;
      5'd2:    atan_lut = 32'd131521918;
      5'd3:    atan_lut = 32'd66762579;
      5'd4:    atan_lut = 32'd33510843;
      5'd5:    atan_lut = 32'd16771758;
      5'd6:    atan_lut = 32'd8387925;
      5'd7:    atan_lut = 32'd4194219;
      5'd8:    atan_lut = 32'd2097141;
      5'd9:    atan_lut = 32'd1048575;
      5'd10:   atan_lut = 32'd524288;
      5'd30,
      5'd31:   atan_lut = 32'd0;
      default: atan_lut = 32'd1 << (5'd29 - i);
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (in_valid) state_d = StIter;
      StIter:  if (idx_q == LastIdx) state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    busy      = (state_q == StIter) || (state_q == StDone);
    out_valid = (state_q == StDone);
  end

  assign x_sh = $signed(x_q) >>> idx_q;
  assign y_sh = $signed(y_q) >>> idx_q;
  assign atan = atan_lut(idx_q);

  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    z_d   = z_q;
    idx_d = idx_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          x_d   = x_in;
          y_d   = y_in;
          z_d   = z_in;
          idx_d = 5'd0;
        end
      end
      StIter: begin
        // Rotate towards zero residual angle: sign of z picks the direction.
        if (!z_q[31]) begin
          x_d = x_q - y_sh;
          y_d = y_q + x_sh;
          z_d = z_q - atan;
        end else begin
          x_d = x_q + y_sh;
          y_d = y_q - x_sh;
          z_d = z_q + atan;
        end
        if (idx_q != LastIdx) idx_d = idx_q + 5'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q   <= '0;
      y_q   <= '0;
      z_q   <= '0;
      idx_q <= '0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      z_q   <= z_d;
      idx_q <= idx_d;
    end
  end

  assign x_out    = x_q;
  assign y_out    = y_q;
  assign z_out    = z_q;
  assign iter_idx = idx_q;

endmodule
